// File: rtl/rvsteel_gptimer_pkg.sv
// Shared constants for the general-purpose timer: register map, channel layout,
// control bit positions and reset values.
package rvsteel_gptimer_pkg;

    localparam int unsigned ADDR_WIDTH = 8;
    localparam int unsigned DATA_WIDTH = 32;

    localparam logic [7:0] ADDR_CR       = 8'h00;
    localparam logic [7:0] ADDR_PRESCALE = 8'h04;
    localparam logic [7:0] ADDR_MTIMEL   = 8'h08;
    localparam logic [7:0] ADDR_MTIMEH   = 8'h0C;
    localparam logic [7:0] ADDR_STATUS   = 8'h10;
    localparam logic [7:0] ADDR_IE       = 8'h14;

    localparam logic [7:0] CH_BASE   = 8'h20;
    localparam logic [7:0] CH_STRIDE = 8'h10;

    localparam int unsigned CR_EN_BIT        = 0;
    localparam int unsigned CR_CLR_BIT       = 1;
    localparam int unsigned CCR_EN_BIT       = 0;
    localparam int unsigned CCR_PERIODIC_BIT = 1;

    localparam logic [63:0] CMP_RESET = '1;

    // Word select inside one channel's register block
    typedef enum logic [1:0] {
        CH_CMPL   = 2'd0,
        CH_CMPH   = 2'd1,
        CH_PERIOD = 2'd2,
        CH_CCR    = 2'd3
    } ch_reg_e;

endpackage

// File: rtl/rvsteel_gptimer_if.sv
// Register access bus of the timer: one-cycle read and write request/response.
interface rvsteel_gptimer_if
    import rvsteel_gptimer_pkg::*;
();

    logic [ADDR_WIDTH-1:0]   rw_address;
    logic [DATA_WIDTH-1:0]   read_data;
    logic                    read_request;
    logic                    read_response;
    logic [DATA_WIDTH-1:0]   write_data;
    logic [DATA_WIDTH/8-1:0] write_strobe;
    logic                    write_request;
    logic                    write_response;

    modport master (
        output rw_address, read_request, write_data, write_strobe, write_request,
        input  read_data, read_response, write_response
    );

    modport slave (
        input  rw_address, read_request, write_data, write_strobe, write_request,
        output read_data, read_response, write_response
    );

endinterface

// File: rtl/rvsteel_gptimer_channel.sv
// One compare channel: 64-bit compare value, optional periodic reload, match flag.
module rvsteel_gptimer_channel
    import rvsteel_gptimer_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic [63:0] mtime,
    input  logic [31:0] write_data,
    input  logic        wr_cmpl,
    input  logic        wr_cmph,
    input  logic        wr_period,
    input  logic        wr_ccr,
    output logic [63:0] cmp,
    output logic [31:0] period,
    output logic [1:0]  ccr,
    output logic        match
);

    logic reload;

    // A compare write in flight makes the current cmp stale, so no match that cycle
    assign match  = ccr[CCR_EN_BIT] && (mtime >= cmp) && !(wr_cmpl || wr_cmph);
    assign reload = match && ccr[CCR_PERIODIC_BIT] && (period != '0);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cmp    <= CMP_RESET;
            period <= '0;
            ccr    <= '0;
        end else begin
            if (reload) cmp <= cmp + {32'b0, period};
            if (wr_cmpl) cmp[31:0] <= write_data;
            if (wr_cmph) cmp[63:32] <= write_data;
            if (wr_period) period <= write_data;
            if (wr_ccr) ccr <= write_data[1:0];
        end
    end

endmodule

// File: rtl/rvsteel_gptimer.sv
// General-purpose timer: prescaled 64-bit mtime, NUM_CHANNELS compare channels,
// W1C status and registered per-channel interrupts.
module rvsteel_gptimer
    import rvsteel_gptimer_pkg::*;
#(
    parameter int NUM_CHANNELS    = 4,
    parameter int PRESCALER_WIDTH = 16
) (
    input  logic                    clock,
    input  logic                    reset,
    rvsteel_gptimer_if.slave        bus,
    output logic [NUM_CHANNELS-1:0] irq
);

    logic                       cr_en;
    logic [PRESCALER_WIDTH-1:0] prescale;
    logic [PRESCALER_WIDTH-1:0] presc_cnt;
    logic [63:0]                mtime;
    logic [63:0]                mtime_ticked;
    logic [NUM_CHANNELS-1:0]    status;
    logic [NUM_CHANNELS-1:0]    ie;
    logic [NUM_CHANNELS-1:0]    match;
    logic [NUM_CHANNELS-1:0]    w1c;

    logic [63:0] cmp    [NUM_CHANNELS];
    logic [31:0] period [NUM_CHANNELS];
    logic [1:0]  ccr    [NUM_CHANNELS];

    logic        aligned;
    logic        wr_ok;
    logic        ch_valid;
    logic [7:0]  ch_idx;
    ch_reg_e     ch_reg;
    logic        wr_cr, wr_prescale, wr_mtimel, wr_mtimeh, wr_status, wr_ie;
    logic        clr;
    logic        tick;
    logic [31:0] rd_mux;

    assign aligned  = bus.rw_address[1:0] == 2'b00;
    assign ch_idx   = (bus.rw_address - CH_BASE) / CH_STRIDE;
    assign ch_valid = (bus.rw_address >= CH_BASE) && (ch_idx < 8'(NUM_CHANNELS));
    assign ch_reg   = ch_reg_e'(bus.rw_address[3:2]);
    assign wr_ok    = bus.write_request && aligned && (bus.write_strobe == 4'hF);

    assign wr_cr       = wr_ok && (bus.rw_address == ADDR_CR);
    assign wr_prescale = wr_ok && (bus.rw_address == ADDR_PRESCALE);
    assign wr_mtimel   = wr_ok && (bus.rw_address == ADDR_MTIMEL);
    assign wr_mtimeh   = wr_ok && (bus.rw_address == ADDR_MTIMEH);
    assign wr_status   = wr_ok && (bus.rw_address == ADDR_STATUS);
    assign wr_ie       = wr_ok && (bus.rw_address == ADDR_IE);

    assign clr          = wr_cr && bus.write_data[CR_CLR_BIT];
    assign tick         = cr_en && (presc_cnt == prescale);
    assign mtime_ticked = mtime + 64'(tick);
    assign w1c          = wr_status ? bus.write_data[NUM_CHANNELS-1:0] : '0;

    always_comb begin
        rd_mux = '0;
        if (aligned) begin
            case (bus.rw_address)
                ADDR_CR:       rd_mux[CR_EN_BIT] = cr_en;
                ADDR_PRESCALE: rd_mux[PRESCALER_WIDTH-1:0] = prescale;
                ADDR_MTIMEL:   rd_mux = mtime[31:0];
                ADDR_MTIMEH:   rd_mux = mtime[63:32];
                ADDR_STATUS:   rd_mux[NUM_CHANNELS-1:0] = status;
                ADDR_IE:       rd_mux[NUM_CHANNELS-1:0] = ie;
                default: begin
                    for (int unsigned n = 0; n < NUM_CHANNELS; n++) begin
                        if (ch_valid && (ch_idx == n[7:0])) begin
                            case (ch_reg)
                                CH_CMPL:   rd_mux = cmp[n][31:0];
                                CH_CMPH:   rd_mux = cmp[n][63:32];
                                CH_PERIOD: rd_mux = period[n];
                                CH_CCR:    rd_mux[1:0] = ccr[n];
                            endcase
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            bus.read_data      <= '0;
            bus.read_response  <= 1'b0;
            bus.write_response <= 1'b0;
            cr_en              <= 1'b0;
            prescale           <= '0;
            presc_cnt          <= '0;
            mtime              <= '0;
            status             <= '0;
            ie                 <= '0;
            irq                <= '0;
        end else begin
            bus.read_response  <= bus.read_request;
            bus.write_response <= bus.write_request;
            if (bus.read_request) bus.read_data <= rd_mux;

            if (wr_cr) cr_en <= bus.write_data[CR_EN_BIT];
            if (wr_prescale) prescale <= bus.write_data[PRESCALER_WIDTH-1:0];

            // CLR wins over both the tick and any half-word mtime write
            if (clr) begin
                presc_cnt <= '0;
                mtime     <= '0;
            end else begin
                if (tick) presc_cnt <= '0;
                else if (cr_en) presc_cnt <= presc_cnt + PRESCALER_WIDTH'(1);
                mtime <= mtime_ticked;
                if (wr_mtimel) mtime[31:0] <= bus.write_data;
                if (wr_mtimeh) mtime[63:32] <= bus.write_data;
            end

            status <= (status & ~w1c) | match;
            if (wr_ie) ie <= bus.write_data[NUM_CHANNELS-1:0];
            irq <= status & ie;
        end
    end

    for (genvar n = 0; n < NUM_CHANNELS; n++) begin : g_ch
        logic ch_sel;
        assign ch_sel = wr_ok && ch_valid && (ch_idx == 8'(n));

        rvsteel_gptimer_channel u_channel (
            .clock      (clock),
            .reset      (reset),
            .mtime      (mtime),
            .write_data (bus.write_data),
            .wr_cmpl    (ch_sel && (ch_reg == CH_CMPL)),
            .wr_cmph    (ch_sel && (ch_reg == CH_CMPH)),
            .wr_period  (ch_sel && (ch_reg == CH_PERIOD)),
            .wr_ccr     (ch_sel && (ch_reg == CH_CCR)),
            .cmp        (cmp[n]),
            .period     (period[n]),
            .ccr        (ccr[n]),
            .match      (match[n])
        );
    end

endmodule

// File: tb/tb_rvsteel_gptimer.sv
// Self-checking bench for rvsteel_gptimer: directed scenarios with literal
// expectations plus randomized bus traffic compared every cycle against a model.
module tb_rvsteel_gptimer;

    localparam int NCH = 4;
    localparam int PW  = 16;

    logic           clock = 1'b0;
    logic           reset = 1'b0;
    logic [NCH-1:0] irq;

    rvsteel_gptimer_if bus_if ();

    rvsteel_gptimer #(
        .NUM_CHANNELS    (NCH),
        .PRESCALER_WIDTH (PW)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus_if),
        .irq   (irq)
    );

    always #5 clock = ~clock;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Reference model state, kept as plain numbers
    longint unsigned m_mtime;
    int unsigned     m_pcnt;
    int unsigned     m_prescale;
    bit              m_en;
    bit [7:0]        m_status;
    bit [7:0]        m_ie;
    bit [7:0]        m_irq;
    longint unsigned m_cmp    [NCH];
    longint unsigned m_period [NCH];
    bit [1:0]        m_ccr    [NCH];
    bit [31:0]       m_rdata;
    bit              m_rresp;
    bit              m_wresp;

    localparam bit [7:0] CH_MASK = 8'((1 << NCH) - 1);

    function automatic bit [31:0] model_read(input int unsigned a);
        int unsigned ch;
        int unsigned off;
        if (a % 4 != 0) return 32'd0;
        if (a == 'h00) return {31'd0, m_en};
        if (a == 'h04) return m_prescale;
        if (a == 'h08) return m_mtime[31:0];
        if (a == 'h0C) return m_mtime[63:32];
        if (a == 'h10) return {24'd0, m_status};
        if (a == 'h14) return {24'd0, m_ie};
        if (a >= 'h20) begin
            ch  = (a - 'h20) / 16;
            off = (a - 'h20) % 16;
            if (ch < NCH) begin
                if (off == 0)  return m_cmp[ch][31:0];
                if (off == 4)  return m_cmp[ch][63:32];
                if (off == 8)  return m_period[ch][31:0];
                if (off == 12) return {30'd0, m_ccr[ch]};
            end
        end
        return 32'd0;
    endfunction

    task automatic model_reset();
        m_mtime = 0; m_pcnt = 0; m_prescale = 0; m_en = 0;
        m_status = 0; m_ie = 0; m_irq = 0;
        m_rdata = 0; m_rresp = 0; m_wresp = 0;
        for (int n = 0; n < NCH; n++) begin
            m_cmp[n] = 64'hFFFF_FFFF_FFFF_FFFF;
            m_period[n] = 0;
            m_ccr[n] = 0;
        end
    endtask

    task automatic model_step();
        int unsigned     a;
        bit [31:0]       wd;
        bit              wr;
        bit              tick;
        bit [7:0]        hit;
        longint unsigned t;
        bit [31:0]       rd;
        int              wch;
        int unsigned     woff;
        a    = bus_if.rw_address;
        wd   = bus_if.write_data;
        wr   = bus_if.write_request && (a % 4 == 0) && (bus_if.write_strobe == 4'hF);
        tick = m_en && (m_pcnt == m_prescale);
        t    = m_mtime + (tick ? 1 : 0);
        rd   = model_read(a);
        hit  = 0;
        wch  = -1;
        woff = 0;
        if (wr && a >= 'h20 && (a - 'h20) / 16 < NCH) begin
            wch  = (a - 'h20) / 16;
            woff = (a - 'h20) % 16;
        end
        for (int n = 0; n < NCH; n++)
            if (m_ccr[n][0] && m_mtime >= m_cmp[n] && !(wch == n && woff < 8)) hit[n] = 1;

        m_irq = m_status & m_ie;
        if (wr && a == 'h10) m_status = m_status & ~wd[7:0];
        m_status = (m_status | hit) & CH_MASK;
        if (wr && a == 'h14) m_ie = wd[7:0] & CH_MASK;

        for (int n = 0; n < NCH; n++)
            if (hit[n] && m_ccr[n][1] && m_period[n] != 0) m_cmp[n] = m_cmp[n] + m_period[n];
        if (wch >= 0) begin
            if (woff == 0)  m_cmp[wch] = {m_cmp[wch][63:32], wd};
            if (woff == 4)  m_cmp[wch] = {wd, m_cmp[wch][31:0]};
            if (woff == 8)  m_period[wch] = wd;
            if (woff == 12) m_ccr[wch] = wd[1:0];
        end

        if (m_en) m_pcnt = tick ? 0 : (m_pcnt + 1) % (1 << PW);
        m_mtime = t;
        if (wr && a == 'h08) m_mtime = {t[63:32], wd};
        if (wr && a == 'h0C) m_mtime = {wd, t[31:0]};
        if (wr && a == 'h04) m_prescale = wd % (1 << PW);
        if (wr && a == 'h00) begin
            m_en = wd[0];
            if (wd[1]) begin
                m_mtime = 0;
                m_pcnt = 0;
            end
        end

        m_wresp = bus_if.write_request;
        m_rresp = bus_if.read_request;
        if (bus_if.read_request) m_rdata = rd;
    endtask

    always @(posedge clock or posedge reset) begin
        if (reset) model_reset();
        else model_step();
    end

    initial begin
        forever begin
            @(negedge clock);
            check("irq", irq, m_irq);
            check("read_response", bus_if.read_response, m_rresp);
            check("write_response", bus_if.write_response, m_wresp);
            check("read_data", bus_if.read_data, m_rdata);
        end
    end

    task automatic bus_write(input bit [7:0] a, input bit [31:0] d, input bit [3:0] s = 4'hF);
        bus_if.rw_address    = a;
        bus_if.write_data    = d;
        bus_if.write_strobe  = s;
        bus_if.write_request = 1'b1;
        @(posedge clock); #1;
        bus_if.write_request = 1'b0;
    endtask

    task automatic bus_read(input bit [7:0] a, output bit [31:0] d);
        bus_if.rw_address   = a;
        bus_if.read_request = 1'b1;
        @(posedge clock); #1;
        bus_if.read_request = 1'b0;
        check("read_latency", bus_if.read_response, 1'b1);
        d = bus_if.read_data;
    endtask

    task automatic wait_irq(input int b, input bit val, input int budget, input string name);
        int k;
        k = 0;
        while (irq[b] !== val && k < budget) begin
            @(negedge clock);
            k++;
        end
        check(name, irq[b], val);
    endtask

    function automatic bit [7:0] pick_addr();
        int unsigned r;
        r = $urandom_range(0, 9);
        if (r < 4) return 8'(4 * $urandom_range(0, 5));
        if (r < 9) return 8'('h20 + 16 * $urandom_range(0, NCH - 1) + 4 * $urandom_range(0, 3));
        return 8'($urandom);
    endfunction

    function automatic bit [31:0] pick_data(input bit [7:0] a);
        int unsigned r;
        r = $urandom_range(0, 19);
        case (a)
            8'h00: return (r == 0) ? 32'd3 : ((r == 1) ? 32'd0 : 32'd1);
            8'h04: return 32'($urandom_range(0, 3));
            8'h08: return 32'($urandom_range(0, 500));
            8'h0C: return (r == 0) ? 32'($urandom) : 32'd0;
            8'h10: return 32'($urandom);
            8'h14: return 32'($urandom);
            default: begin
                if (a < 8'h20) return 32'($urandom);
                case (a[3:0])
                    4'h0:    return m_mtime[31:0] + 32'($urandom_range(0, 60));
                    4'h4:    return m_mtime[63:32];
                    4'h8:    return 32'($urandom_range(0, 30));
                    default: return 32'($urandom_range(0, 3));
                endcase
            end
        endcase
    endfunction

    initial begin
        #3_000_000;
        n_fail++;
        $display("FAIL watchdog: time limit reached before end of stimulus");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        bit [31:0] rd;
        bit [31:0] rd2;
        int unsigned op;
        bit [7:0] ra;
        bus_if.rw_address    = '0;
        bus_if.write_data    = '0;
        bus_if.write_strobe  = '0;
        bus_if.write_request = 1'b0;
        bus_if.read_request  = 1'b0;

        // Reset with no clock edge seen yet
        #2 reset = 1'b1;
        #1;
        check("reset_irq", irq, 0);
        check("reset_read_data", bus_if.read_data, 0);
        check("reset_read_response", bus_if.read_response, 0);
        check("reset_write_response", bus_if.write_response, 0);
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(posedge clock); #1;

        bus_read(8'h00, rd); check("cr_reset", rd, 0);
        bus_read(8'h04, rd); check("prescale_reset", rd, 0);
        bus_read(8'h24, rd); check("cmph_reset", rd, 32'hFFFF_FFFF);
        bus_read(8'h28, rd); check("period_reset", rd, 0);

        // PRESCALE=3: one tick every 4 clocks
        bus_write(8'h04, 3);
        bus_write(8'h00, 1);
        repeat (40) @(posedge clock); #1;
        bus_read(8'h08, rd);
        check("mtime_prescale3_in_9_11", (rd >= 9 && rd <= 11), 1);

        // PRESCALE=0: one tick every clock
        bus_write(8'h04, 0);
        bus_write(8'h00, 3);
        bus_read(8'h08, rd);
        repeat (5) @(posedge clock); #1;
        bus_read(8'h08, rd2);
        check("mtime_prescale0_step", rd2 - rd, 6);

        // Carry from MTIMEL into MTIMEH on exactly one tick
        bus_write(8'h00, 2);
        bus_write(8'h08, 32'hFFFF_FFFF);
        bus_write(8'h0C, 0);
        bus_write(8'h00, 1);
        bus_write(8'h00, 0);
        bus_read(8'h0C, rd); check("carry_mtimeh", rd, 1);
        bus_read(8'h08, rd); check("carry_mtimel", rd, 0);

        // One-shot channel 0 at mtime 100
        bus_write(8'h00, 2);
        bus_write(8'h20, 100);
        bus_write(8'h24, 0);
        bus_write(8'h14, 1);
        bus_write(8'h2C, 1);
        bus_write(8'h00, 1);
        wait_irq(0, 1'b1, 200, "irq0_rise");
        bus_read(8'h08, rd);
        check("irq0_rise_mtime_window", (rd >= 100 && rd <= 104), 1);
        bus_write(8'h10, 1);
        bus_read(8'h10, rd); check("status0_persists", rd, 1);
        bus_write(8'h24, 32'hFFFF_FFFF);
        bus_write(8'h10, 1);
        repeat (2) @(posedge clock); #1;
        check("irq0_cleared", irq[0], 0);
        bus_read(8'h10, rd); check("status0_cleared", rd, 0);
        bus_write(8'h2C, 0);

        // Periodic channel 1: 50, then 75, then 100
        bus_write(8'h00, 2);
        bus_write(8'h30, 50);
        bus_write(8'h34, 0);
        bus_write(8'h38, 25);
        bus_write(8'h14, 2);
        bus_write(8'h3C, 3);
        bus_write(8'h00, 1);
        wait_irq(1, 1'b1, 200, "irq1_first");
        bus_read(8'h30, rd); check("cmp1_after_first", rd, 75);
        bus_write(8'h10, 2);
        bus_read(8'h10, rd); check("status1_cleared", rd, 0);
        wait_irq(1, 1'b0, 10, "irq1_fall");
        wait_irq(1, 1'b1, 100, "irq1_second");
        bus_read(8'h30, rd); check("cmp1_after_second", rd, 100);

        // W1C racing a live match, unmapped reads, partial strobes
        bus_write(8'h00, 2);
        bus_write(8'h3C, 0);
        bus_write(8'h10, 32'hF);
        bus_write(8'h20, 20);
        bus_write(8'h24, 0);
        bus_write(8'h2C, 1);
        bus_write(8'h14, 1);
        bus_write(8'h00, 1);
        repeat (30) @(posedge clock); #1;
        bus_write(8'h10, 1);
        bus_read(8'h10, rd); check("w1c_loses_to_match", rd, 1);
        bus_read(8'hF0, rd); check("read_unmapped_f0", rd, 0);
        bus_read(8'h11, rd); check("read_misaligned", rd, 0);
        bus_read(8'h18, rd); check("read_hole_18", rd, 0);
        bus_read(8'h60, rd); check("read_channel_out_of_range", rd, 0);
        bus_write(8'h14, 0, 4'b0011);
        bus_read(8'h14, rd); check("partial_strobe_ignored", rd, 1);
        bus_write(8'h21, 7);
        bus_read(8'h20, rd); check("misaligned_write_ignored", rd, 20);

        // Asynchronous reset mid-count with a pending channel and a response in flight
        wait_irq(0, 1'b1, 10, "irq0_pending_before_reset");
        bus_if.rw_address   = 8'h08;
        bus_if.read_request = 1'b1;
        @(posedge clock); #2;
        reset = 1'b1;
        #1;
        bus_if.read_request = 1'b0;
        check("async_reset_irq", irq, 0);
        check("async_reset_read_response", bus_if.read_response, 0);
        check("async_reset_read_data", bus_if.read_data, 0);
        check("async_reset_write_response", bus_if.write_response, 0);
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock); #1;
        bus_read(8'h08, rd); check("post_reset_mtimel", rd, 0);
        bus_read(8'h10, rd); check("post_reset_status", rd, 0);
        bus_read(8'h14, rd); check("post_reset_ie", rd, 0);
        bus_read(8'h20, rd); check("post_reset_cmpl", rd, 32'hFFFF_FFFF);
        bus_read(8'h2C, rd); check("post_reset_ccr", rd, 0);
        bus_read(8'h38, rd); check("post_reset_period1", rd, 0);

        // Randomized traffic, checked every cycle by the compare process
        bus_write(8'h04, 1);
        bus_write(8'h00, 1);
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) begin
                bus_if.read_request  = 1'b0;
                bus_if.write_request = 1'b0;
                #2 reset = 1'b1;
                #1 check("random_reset_irq", irq, 0);
                @(negedge clock);
                reset = 1'b0;
                @(posedge clock); #1;
                bus_write(8'h00, 1);
            end
            op = $urandom_range(0, 3);
            ra = pick_addr();
            bus_if.rw_address    = ra;
            bus_if.read_request  = op[0];
            bus_if.write_request = op[1];
            bus_if.write_data    = pick_data(ra);
            bus_if.write_strobe  = ($urandom_range(0, 9) == 0) ? 4'($urandom) : 4'hF;
            @(posedge clock); #1;
        end
        bus_if.read_request  = 1'b0;
        bus_if.write_request = 1'b0;
        repeat (3) @(posedge clock);
        #1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
